// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    PUSH = 1'b1
  } rx_coll_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int BREAK_BITS_DEF = 11;

endpackage

// File: rtl/uart_tick_counter.sv
// Saturating tick counter with terminal-count flag and one-cycle-early reach strobe.
module uart_tick_counter #(
  parameter int TERMINAL = 176
) (
  input  logic CLK,
  input  logic nRST,
  input  logic tick,
  input  logic clear,
  output logic terminal,
  output logic reach
);

  localparam int W = $clog2(TERMINAL + 1);
  localparam logic [W-1:0] TC    = W'(TERMINAL);
  localparam logic [W-1:0] TC_M1 = W'(TERMINAL - 1);

  logic [W-1:0] count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != TC)) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == TC);
  // High on the tick that will land the count on TERMINAL.
  assign reach    = tick & ~clear & (count == TC_M1);

endmodule

// File: rtl/uart_rx_collector.sv
// RX glue between UartRxEn and the RX FIFO: byte push, error/overrun/break status.
// Optional idle-timeout detection is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_collector
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int BREAK_BITS   = BREAK_BITS_DEF,
  parameter int TIMEOUT_BITS = 32,
  parameter int ERRCNT_W     = 8
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                rx_en,
  input  logic                rx_in,
  input  logic                rx_done,
  input  logic                rx_err,
  input  logic [7:0]          rx_data,
  input  logic                fifo_full,
  output logic                fifo_wen,
  output logic [8:0]          fifo_wdata,
  input  logic                clear,
  output logic                overrun,
  output logic                frame_err,
  output logic [ERRCNT_W-1:0] err_count,
  output logic                line_break,
  output logic                break_pulse,
  output logic                timeout
);

  localparam int BRK_TC = BREAK_BITS * OVERSAMPLE;

  rx_coll_state_t state;
  rx_entry_t      entry;
  logic           ferr_pend;
  logic           done_q;
  logic           err_q;
  logic           push_ok;
  logic           brk_clr;
  logic           brk_reach;

  assign done_q  = rx_en & rx_done;
  assign err_q   = rx_en & rx_err;
  assign push_ok = (state == PUSH) & ~fifo_full;

  // rx_data only becomes valid in the PUSH cycle, so the write path is taken straight from it.
  always_comb begin
    entry = '0;
    if (state == PUSH) begin
      entry.ferr = ferr_pend;
      entry.data = rx_data;
    end
  end

  assign fifo_wen   = push_ok;
  assign fifo_wdata = entry;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      ferr_pend   <= 1'b0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
      break_pulse <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (done_q) state <= PUSH;
        PUSH:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Set events take priority over clear and over the post-push release.
      if (err_q)                         ferr_pend <= 1'b1;
      else if ((state == PUSH) || clear) ferr_pend <= 1'b0;

      if ((state == PUSH) && fifo_full) overrun <= 1'b1;
      else if (clear)                   overrun <= 1'b0;

      if (err_q)      frame_err <= 1'b1;
      else if (clear) frame_err <= 1'b0;

      if (err_q) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
      end else if (clear) begin
        err_count <= '0;
      end

      break_pulse <= brk_reach;
    end
  end

  assign brk_clr = clear | (rx_en & rx_in);

  uart_tick_counter #(
    .TERMINAL(BRK_TC)
  ) u_brk (
    .CLK     (CLK),
    .nRST    (nRST),
    .tick    (rx_en),
    .clear   (brk_clr),
    .terminal(line_break),
    .reach   (brk_reach)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_TC = TIMEOUT_BITS * OVERSAMPLE;

  logic to_armed;
  logic to_clr;
  logic to_term;
  logic to_reach;

  // Counter only runs while armed; line activity, new bytes or a disarm hold it at zero.
  assign to_clr = clear | done_q | (rx_en & ~rx_in) | ~to_armed | to_term;

  uart_tick_counter #(
    .TERMINAL(TO_TC)
  ) u_to (
    .CLK     (CLK),
    .nRST    (nRST),
    .tick    (rx_en),
    .clear   (to_clr),
    .terminal(to_term),
    .reach   (to_reach)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      to_armed <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (push_ok)                 to_armed <= 1'b1;
      else if (to_reach || clear)  to_armed <= 1'b0;

      if (to_reach)   timeout <= 1'b1;
      else if (clear) timeout <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_collector.sv
// Randomized self-checking bench for uart_rx_collector against a transaction-level model.
module tb_uart_rx_collector;

  logic       CLK;
  logic       nRST;
  logic       rx_en;
  logic       rx_in;
  logic       rx_done;
  logic       rx_err;
  logic [7:0] rx_data;
  logic       fifo_full;
  logic       fifo_wen;
  logic [8:0] fifo_wdata;
  logic       clear;
  logic       overrun;
  logic       frame_err;
  logic [7:0] err_count;
  logic       line_break;
  logic       break_pulse;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  int m_err_count;
  bit m_pend;
  bit m_overrun;
  bit m_frame_err;
  bit m_line_break;
  bit m_timeout;

  uart_rx_collector #(
    .OVERSAMPLE  (16),
    .BREAK_BITS  (11),
    .TIMEOUT_BITS(4),
    .ERRCNT_W    (8)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .rx_en      (rx_en),
    .rx_in      (rx_in),
    .rx_done    (rx_done),
    .rx_err     (rx_err),
    .rx_data    (rx_data),
    .fifo_full  (fifo_full),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .clear      (clear),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .err_count  (err_count),
    .line_break (line_break),
    .break_pulse(break_pulse),
    .timeout    (timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic modelErr();
    m_pend      = 1'b1;
    m_frame_err = 1'b1;
    if (m_err_count < 255) m_err_count++;
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, ".overrun"},    32'(overrun),    32'(m_overrun));
    checkOutput({tag, ".frame_err"},  32'(frame_err),  32'(m_frame_err));
    checkOutput({tag, ".err_count"},  32'(err_count),  m_err_count);
    checkOutput({tag, ".line_break"}, 32'(line_break), 32'(m_line_break));
    checkOutput({tag, ".timeout"},    32'(timeout),    32'(m_timeout));
  endtask

  task automatic doClear();
    clear = 1'b1;
    cycle();
    clear       = 1'b0;
    m_pend      = 1'b0;
    m_overrun   = 1'b0;
    m_frame_err = 1'b0;
    m_err_count = 0;
    m_timeout   = 1'b0;
  endtask

  task automatic idleTicks(input int n);
    for (int k = 0; k < n; k++) begin
      rx_en = 1'b1;
      rx_in = 1'b1;
      cycle();
    end
    rx_en = 1'b0;
  endtask

  // One received byte: optional earlier error, qualified done, then the byte appears a cycle later.
  task automatic applyStimulus(input logic [7:0] data, input bit err_before,
                               input bit err_with_done, input bit full);
    if (err_before) begin
      rx_en  = 1'b1;
      rx_err = 1'b1;
      cycle();
      rx_en  = 1'b0;
      rx_err = 1'b0;
      modelErr();
    end
    rx_in   = 1'b1;
    rx_en   = 1'b1;
    rx_done = 1'b1;
    rx_err  = err_with_done;
    rx_data = 8'($urandom);
    @(negedge CLK);
    checkOutput("wen_pre", 32'(fifo_wen), 32'd0);
    cycle();
    if (err_with_done) modelErr();
    rx_en     = 1'b0;
    rx_done   = 1'b0;
    rx_err    = 1'b0;
    rx_data   = data;
    fifo_full = full;
    @(negedge CLK);
    checkOutput("wen", 32'(fifo_wen), 32'(!full));
    if (!full) checkOutput("wdata", 32'(fifo_wdata), {23'd0, m_pend, data});
    else m_overrun = 1'b1;
    m_pend = 1'b0;
    cycle();
    rx_data   = 8'($urandom);
    fifo_full = 1'($urandom);
    @(negedge CLK);
    checkOutput("wen_post", 32'(fifo_wen), 32'd0);
    checkFlags("byte");
    cycle();
    fifo_full = 1'b0;
  endtask

  initial begin
    int pulses;
    int pulse_tick;

    nRST = 1'b0; rx_en = 1'b0; rx_in = 1'b1; rx_done = 1'b0; rx_err = 1'b0;
    rx_data = 8'h00; fifo_full = 1'b0; clear = 1'b0;
    m_err_count = 0; m_pend = 0; m_overrun = 0; m_frame_err = 0; m_line_break = 0; m_timeout = 0;
    repeat (3) cycle();
    checkOutput("reset.wen",   32'(fifo_wen),    32'd0);
    checkOutput("reset.wdata", 32'(fifo_wdata),  32'd0);
    checkOutput("reset.pulse", 32'(break_pulse), 32'd0);
    checkFlags("reset");
    nRST = 1'b1;
    cycle();

    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h3D, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h6E, 1'b0, 1'b1, 1'b0);

    // Done and error without the oversample tick must be ignored.
    rx_en = 1'b0; rx_done = 1'b1; rx_err = 1'b1;
    cycle();
    rx_done = 1'b0; rx_err = 1'b0;
    @(negedge CLK);
    checkOutput("unq.wen", 32'(fifo_wen), 32'd0);
    checkFlags("unq");
    cycle();

    applyStimulus(8'h55, 1'b0, 1'b0, 1'b1);
    doClear();
    checkFlags("clear");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) doClear();
      applyStimulus(8'($urandom), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
    end

    // Line break: 176 low ticks declare it; an error during the break still counts.
    pulses = 0;
    pulse_tick = 0;
    for (int k = 1; k <= 200; k++) begin
      rx_en  = 1'b1;
      rx_in  = 1'b0;
      rx_err = (k == 180);
      cycle();
      if (k == 180) modelErr();
      if (break_pulse) begin
        pulses++;
        pulse_tick = k;
      end
      if (k == 175) checkOutput("brk.before", 32'(line_break), 32'd0);
      if (k == 176) checkOutput("brk.at",     32'(line_break), 32'd1);
    end
    rx_err = 1'b0;
    checkOutput("brk.pulses",    pulses,     32'd1);
    checkOutput("brk.pulse_tick", pulse_tick, 32'd176);
    m_line_break = 1'b1;
    checkFlags("brk.hold");
    rx_in = 1'b1;
    cycle();
    rx_en = 1'b0;
    m_line_break = 1'b0;
    checkFlags("brk.end");

    // Error counter saturation.
    doClear();
    for (int k = 1; k <= 300; k++) begin
      rx_en  = 1'b1;
      rx_err = 1'b1;
      cycle();
      modelErr();
      if (k == 254) checkOutput("sat.254", 32'(err_count), 32'd254);
      if (k == 255) checkOutput("sat.255", 32'(err_count), 32'd255);
    end
    rx_en = 1'b0; rx_err = 1'b0;
    cycle();
    checkFlags("sat");

    doClear();
    idleTicks(100);
    checkOutput("to.unarmed", 32'(timeout), 32'd0);
    applyStimulus(8'h42, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_TIMEOUT_EN
    idleTicks(63);
    checkOutput("to.63", 32'(timeout), 32'd0);
    idleTicks(1);
    checkOutput("to.64", 32'(timeout), 32'd1);
    m_timeout = 1'b1;
    idleTicks(200);
    checkFlags("to.sticky");
    doClear();
    idleTicks(200);
    checkOutput("to.norearm", 32'(timeout), 32'd0);
`else
    idleTicks(200);
    checkOutput("to.absent", 32'(timeout), 32'd0);
`endif

    // Reset during a pending push must drop the write.
    applyStimulus(8'h19, 1'b1, 1'b0, 1'b0);
    rx_en = 1'b1; rx_done = 1'b1;
    cycle();
    rx_en = 1'b0; rx_done = 1'b0; rx_data = 8'h77;
    nRST = 1'b0;
    #1;
    checkOutput("rst.wen", 32'(fifo_wen), 32'd0);
    m_pend = 0; m_overrun = 0; m_frame_err = 0; m_err_count = 0; m_timeout = 0;
    checkFlags("rst");
    @(negedge CLK);
    nRST = 1'b1;
    cycle();
    @(negedge CLK);
    checkOutput("rst.after", 32'(fifo_wen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
